alu_mc: RTL and testbench

- Parametrised, multi-cycle successor to the team's combinational 5-bit-opcode ALU.
- Registers operands via a valid/ready input handshake and executes the original logic/arith ops plus shifts, compares and an optional iterative multiply.
- Presents the result with status flags on a valid/ready output handshake.
- Sits between the decode/issue stage and writeback of the MIPS datapath.

---
 rtl/alu_mc.sv | 199 +++++++++++++++++++
 tb/tb_alu_mc.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes on both sides and registered result/flags.
// Define ALU_MC_MUL_EN to build the iterative shift-add multiplier (opcode 0C).
module alu_mc #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic [4:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             op_err
);

  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_ADD  = 5'h01;
  localparam logic [4:0] OP_SUB  = 5'h02;
  localparam logic [4:0] OP_AND  = 5'h03;
  localparam logic [4:0] OP_OR   = 5'h04;
  localparam logic [4:0] OP_XOR  = 5'h05;
  localparam logic [4:0] OP_NOR  = 5'h06;
  localparam logic [4:0] OP_SLL  = 5'h07;
  localparam logic [4:0] OP_SRL  = 5'h08;
  localparam logic [4:0] OP_SRA  = 5'h09;
  localparam logic [4:0] OP_SLT  = 5'h0A;
  localparam logic [4:0] OP_SLTU = 5'h0B;
`ifdef ALU_MC_MUL_EN
  localparam logic [4:0] OP_MUL  = 5'h0C;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DONE = 2'd1
`ifdef ALU_MC_MUL_EN
    , BUSY = 2'd2
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic [WIDTH:0]   sum, diff;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] f_res;
  logic             f_c, f_v, f_err;

`ifdef ALU_MC_MUL_EN
  logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, acc_n;
  logic [SHW-1:0]   cnt_q, cnt_d;
`endif

  // Single-cycle datapath, evaluated on the operands present at the accept edge.
  always_comb begin
    sum   = {1'b0, alu_a} + {1'b0, alu_b};
    diff  = {1'b0, alu_a} - {1'b0, alu_b};
    sh    = alu_b[SHW-1:0];
    f_res = '0;
    f_c   = 1'b0;
    f_v   = 1'b0;
    f_err = 1'b0;
    case (alu_op)
      OP_NOP:  f_res = '0;
      OP_ADD: begin
        f_res = sum[WIDTH-1:0];
        f_c   = sum[WIDTH];
        f_v   = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (sum[WIDTH-1] != alu_a[WIDTH-1]);
      end
      OP_SUB: begin
        f_res = diff[WIDTH-1:0];
        f_c   = diff[WIDTH];
        f_v   = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (diff[WIDTH-1] != alu_a[WIDTH-1]);
      end
      OP_AND:  f_res = alu_a & alu_b;
      OP_OR:   f_res = alu_a | alu_b;
      OP_XOR:  f_res = alu_a ^ alu_b;
      OP_NOR:  f_res = ~(alu_a | alu_b);
      OP_SLL:  f_res = alu_a << sh;
      OP_SRL:  f_res = alu_a >> sh;
      OP_SRA:  f_res = $signed(alu_a) >>> sh;
      OP_SLT:  f_res = {{(WIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      OP_SLTU: f_res = {{(WIDTH-1){1'b0}}, (alu_a < alu_b)};
`ifdef ALU_MC_MUL_EN
      OP_MUL:  f_res = '0;
`endif
      default: f_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
`ifdef ALU_MC_MUL_EN
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    acc_n    = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
`ifdef ALU_MC_MUL_EN
          if (alu_op == OP_MUL) begin
            state_d  = BUSY;
            acc_d    = '0;
            mcand_d  = alu_a;
            mplier_d = alu_b;
            cnt_d    = '0;
          end else
`endif
          begin
            state_d = DONE;
            res_d   = f_res;
            zero_d  = !f_err && (f_res == '0);
            carry_d = f_c;
            ovf_d   = f_v;
            err_d   = f_err;
          end
        end
      end
`ifdef ALU_MC_MUL_EN
      // One multiplier bit per cycle; the WIDTH-th step registers the product.
      BUSY: begin
        acc_d    = acc_n;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH - 1)) begin
          state_d = DONE;
          res_d   = acc_n;
          zero_d  = (acc_n == '0);
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
`endif
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      res_q    <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
`ifdef ALU_MC_MUL_EN
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
`ifdef ALU_MC_MUL_EN
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign alu_out    = res_q;
  assign flag_zero  = zero_q;
  assign flag_carry = carry_q;
  assign flag_ovf   = ovf_q;
  assign op_err     = err_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: a driver pushes model results, a negedge monitor pops and compares.
// Follows ALU_MC_MUL_EN to decide whether opcode 0C multiplies or is undefined.
module tb_alu_mc;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] alu_a = '0;
  logic [W-1:0] alu_b = '0;
  logic [4:0]   alu_op = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] alu_out;
  logic         flag_zero, flag_carry, flag_ovf, op_err;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .out_valid(out_valid),
    .out_ready(out_ready), .alu_out(alu_out), .flag_zero(flag_zero),
    .flag_carry(flag_carry), .flag_ovf(flag_ovf), .op_err(op_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] a, b, res;
    logic         z, c, v, e;
    int           lat, acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   or_mode = 0;   // 0: always ready, 1: random, 2: stalled
  int   txn = 0;
  logic mon_en = 1'b0;
  logic seen = 1'b0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain 64-bit arithmetic and range tests on the operand values.
  function automatic exp_t model(logic [4:0] op, logic [W-1:0] a, logic [W-1:0] b);
    exp_t   e;
    longint sa, sb2, t;
    logic [63:0] ua, ub, wide;
    int     sh;
    sa = longint'($signed(a));
    sb2 = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    sh = int'(b[4:0]);
    e.op = op; e.a = a; e.b = b;
    e.res = '0; e.c = 1'b0; e.v = 1'b0; e.e = 1'b0; e.lat = 1; e.acc = 0;
    case (op)
      5'h00: e.res = '0;
      5'h01: begin
        wide = ua + ub; e.res = wide[W-1:0]; e.c = (wide > 64'hFFFF_FFFF);
        t = sa + sb2; e.v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      5'h02: begin
        e.res = a - b; e.c = (a < b);
        t = sa - sb2; e.v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      5'h03: e.res = a & b;
      5'h04: e.res = a | b;
      5'h05: e.res = a ^ b;
      5'h06: e.res = ~(a | b);
      5'h07: begin wide = ua << sh; e.res = wide[W-1:0]; end
      5'h08: begin wide = ua >> sh; e.res = wide[W-1:0]; end
      5'h09: begin t = sa >>> sh; e.res = t[W-1:0]; end
      5'h0A: e.res = (sa < sb2) ? 32'd1 : 32'd0;
      5'h0B: e.res = (ua < ub) ? 32'd1 : 32'd0;
`ifdef ALU_MC_MUL_EN
      5'h0C: begin wide = ua * ub; e.res = wide[W-1:0]; e.lat = W + 1; end
`endif
      default: e.e = 1'b1;
    endcase
    e.z = !e.e && (e.res == '0);
    return e;
  endfunction

  // Present one op (caller is just after a posedge); returns just after its accept edge.
  task automatic issue(logic [4:0] op, logic [W-1:0] a, logic [W-1:0] b, bit hold);
    exp_t e;
    int n = 0;
    in_valid = 1'b1; alu_op = op; alu_a = a; alu_b = b;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", {63'b0, in_ready}, 64'd1);
    else begin
      e = model(op, a, b);
      e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      in_valid = 1'b0;
      alu_a = $urandom; alu_b = $urandom; alu_op = 5'($urandom);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    case (or_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  exp_t m;
  always @(negedge clk) begin
    if (!rst_n) seen = 1'b0;
    else if (mon_en && out_valid) begin
      chk("in_ready_while_out_valid", {63'b0, in_ready}, 64'd0);
      if (sb.size() == 0) chk("unexpected_output", {63'b0, out_valid}, 64'd0);
      else begin
        m = sb[0];
        chk("alu_out", 64'(alu_out), 64'(m.res));
        chk("flags_zcvE", {60'b0, flag_zero, flag_carry, flag_ovf, op_err}, {60'b0, m.z, m.c, m.v, m.e});
        if (!seen) begin
          chk("latency", 64'(cyc - m.acc + 1), 64'(m.lat));
          txn++;
          $display("txn %0d op=%02h a=%08h b=%08h -> out=%08h z=%b c=%b v=%b err=%b lat=%0d",
                   txn, m.op, m.a, m.b, alu_out, flag_zero, flag_carry, flag_ovf, op_err,
                   cyc - m.acc + 1);
          seen = 1'b1;
        end
        if (out_ready) begin
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic [4:0]   rop;
    int n;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {63'b0, out_valid}, 64'd0);
    chk("reset_alu_out", 64'(alu_out), 64'd0);
    chk("reset_flags", {60'b0, flag_zero, flag_carry, flag_ovf, op_err}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_in_ready", {63'b0, in_ready}, 64'd1);
    mon_en = 1'b1;

    // Directed corner cases.
    issue(5'h01, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    issue(5'h01, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    issue(5'h02, 32'd3, 32'd5, 0);
    issue(5'h02, 32'h8000_0000, 32'd1, 0);
    issue(5'h09, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    issue(5'h08, 32'h8000_0000, 32'h0000_001F, 0);
    issue(5'h07, 32'h0000_0001, 32'hFFFF_FFFF, 0);
    issue(5'h0A, 32'h8000_0000, 32'd0, 0);
    issue(5'h0B, 32'h8000_0000, 32'd0, 0);
    issue(5'h1F, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    issue(5'h00, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    issue(5'h06, 32'h0F0F_0000, 32'h00F0_F000, 0);
    issue(5'h0C, 32'h0001_2345, 32'h0000_0100, 0);
    drain();

    // Stall: output and in_ready must hold while out_ready stays low.
    or_mode = 2;
    issue(5'h0C, 32'h0001_2345, 32'h0000_0100, 0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    or_mode = 0;
    drain();

    // Back-to-back with in_valid held high.
    issue(5'h05, 32'hF0F0_F0F0, 32'hFF00_FF00, 1);
    issue(5'h03, 32'hF0F0_F0F0, 32'hFF00_FF00, 1);
    issue(5'h04, 32'hF0F0_F0F0, 32'h0F00_FF00, 1);
    issue(5'h01, 32'd10, 32'd20, 0);
    drain();

    // Random traffic with random backpressure.
    or_mode = 1;
    for (int i = 0; i < 200; i++) begin
      rop = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(13, 31)) : 5'($urandom_range(0, 12));
      case ($urandom_range(0, 3))
        0:       begin ra = 32'h8000_0000; rb = $urandom; end
        1:       begin ra = 32'hFFFF_FFFF; rb = 32'($urandom_range(0, 3)); end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      issue(rop, ra, rb, 1'($urandom_range(0, 1)));
    end
    in_valid = 1'b0;
    or_mode = 0;
    drain();

    // Reset in the middle of a MUL (or a stalled result without the multiplier).
    or_mode = 2;
    issue(5'h0C, 32'h0001_2345, 32'h0000_0100, 0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("midrst_alu_out", 64'(alu_out), 64'd0);
    chk("midrst_flags", {60'b0, flag_zero, flag_carry, flag_ovf, op_err}, 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    or_mode = 0;
    @(posedge clk);
    #1;
    chk("midrst_in_ready", {63'b0, in_ready}, 64'd1);
    issue(5'h01, 32'd1, 32'd1, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
